// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide unit: operation encodings used
// by the decoder and the unit, the controller state type, and small decode
// helpers so the unit and its users classify ops the same way.
// Optional feature macro: MULDIV_MADD_EN (multiply-accumulate ops), consumed
// by muldiv_unit; the encodings below exist in every build.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Plain multiply/divide ops that always run through the iterative core.
    function automatic logic is_base_op(input logic [3:0] o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // Multiply-accumulate family (only honoured when the feature is built in).
    function automatic logic is_madd_op(input logic [3:0] o);
        return (o == OP_MADD) || (o == OP_MADDU) || (o == OP_MSUB) || (o == OP_MSUBU);
    endfunction

    function automatic logic is_msub_op(input logic [3:0] o);
        return (o == OP_MSUB) || (o == OP_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // Ops whose operands are two's complement and need a sign fix-up.
    function automatic logic is_signed_op(input logic [3:0] o);
        return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One radix-2 iteration of the multiply/divide core, purely combinational.
// Operates on unsigned magnitudes held in a {hi, lo} register pair.
//   mode   in  0 = shift-add multiply, 1 = restoring shift-subtract divide
//   hi_in  in  partial product high half / partial remainder
//   lo_in  in  multiplier bits still to consume / dividend bits + quotient
//   opnd   in  multiplicand (multiply) or divisor (divide)
//   hi_out out next high half
//   lo_out out next low half
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole pair right, letting the carry enter the top.
    // Divide: shift the pair left by one, try subtracting the divisor from
    // the widened partial remainder, keep the result only if it fits and
    // record the outcome as the next quotient bit. The difference can be
    // kept at WIDTH bits because a successful subtract is below the divisor.
    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted = {hi_in, lo_in[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - opnd;
        hi_out  = sum[WIDTH:1];
        lo_out  = {sum[0], lo_in[WIDTH-1:1]};
        if (mode) begin
            if (shifted >= {1'b0, opnd}) begin
                hi_out = diff;
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = shifted[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit with the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run for WIDTH+1 cycles under start/busy/done;
// MTHI/MTLO write HI/LO in the cycle start is seen.
// Optional feature macro: MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which
// accumulate the product into {HI,LO}; without it those encodings are ignored.
// Ports:
//   clk         in  clock
//   reset       in  synchronous active-high reset
//   start       in  launch op when idle
//   op          in  operation encoding (muldiv_pkg)
//   opr_a       in  rs: dividend / multiplicand / MTHI, MTLO source
//   opr_b       in  rt: divisor / multiplier
//   busy        out operation in flight
//   done        out one-cycle pulse, HI/LO updated this cycle
//   hi_rdata    out HI register
//   lo_rdata    out LO register
//   div_by_zero out sticky zero-divisor flag, cleared by the next start
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opr_a,
    input  logic [WIDTH-1:0] opr_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_rdata,
    output logic [WIDTH-1:0] lo_rdata,
    output logic             div_by_zero
);

`ifdef MULDIV_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               neg_res;
    logic               neg_rem;
    logic               zero_div;
    logic               done_q;
    logic               dbz_q;

    logic               long_op;
    logic               move_op;
    logic               accept;
    logic               in_signed;
    logic               in_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] hilo_old;
    logic [2*WIDTH-1:0] madd_sum;

    assign long_op   = is_base_op(op) || (MADD_EN && is_madd_op(op));
    assign move_op   = (op == OP_MTHI) || (op == OP_MTLO);
    assign accept    = start && (state == IDLE) && (long_op || move_op);
    assign in_signed = is_signed_op(op);
    assign in_div    = is_div_op(op);
    assign sign_a    = in_signed && opr_a[WIDTH-1];
    assign sign_b    = in_signed && opr_b[WIDTH-1];
    assign abs_a     = sign_a ? -opr_a : opr_a;
    assign abs_b     = sign_b ? -opr_b : opr_b;

    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign hi_rdata    = hi_q;
    assign lo_rdata    = lo_q;
    assign div_by_zero = dbz_q;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode   (is_div_op(op_q)),
        .hi_in  (acc_hi),
        .lo_in  (acc_lo),
        .opnd   (opnd),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    // Controller state register; reset aborts whatever is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: a recognised multi-cycle op leaves IDLE, the iteration
    // phase ends on the last counted step, and the sign fix-up takes one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start && long_op) next_state = CALC;
            CALC: if (cnt == CNT_W'(1)) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Sign fix-up of the unsigned core result. The product is negated as a
    // whole 2*WIDTH value; for divide the quotient follows the operand signs
    // and the remainder follows the dividend. A zero divisor bypasses the
    // core result with the raw dividend and an all-ones quotient. Accumulate
    // ops fold the signed product into the current {HI,LO}, wrapping freely.
    always_comb begin
        prod_mag    = {acc_hi, acc_lo};
        prod_signed = neg_res ? -prod_mag : prod_mag;
        hilo_old    = {hi_q, lo_q};
        madd_sum    = hilo_old + prod_signed;
        fix_hi      = prod_signed[2*WIDTH-1:WIDTH];
        fix_lo      = prod_signed[WIDTH-1:0];
        if (is_div_op(op_q)) begin
            if (zero_div) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem ? -acc_hi : acc_hi;
                fix_lo = neg_res ? -acc_lo : acc_lo;
            end
        end else if (MADD_EN && is_madd_op(op_q)) begin
            if (is_msub_op(op_q)) begin
                madd_sum = hilo_old - prod_signed;
            end
            fix_hi = madd_sum[2*WIDTH-1:WIDTH];
            fix_lo = madd_sum[WIDTH-1:0];
        end
    end

    // Datapath registers. In IDLE an accepted start either writes HI/LO
    // directly (moves) or captures magnitudes and signs for the core; the
    // divide places the dividend in the low half so it shifts into the
    // remainder, the multiply places the multiplier there so its bits are
    // consumed LSB first. HI/LO change only at the end of FIX, so a reset
    // mid-operation can never leave a partial result behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dbz_q <= 1'b0;
                        if (op == OP_MTHI) begin
                            hi_q <= opr_a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= opr_a;
                        end else begin
                            op_q     <= op;
                            cnt      <= CNT_W'(WIDTH);
                            acc_hi   <= '0;
                            acc_lo   <= in_div ? abs_a : abs_b;
                            opnd     <= in_div ? abs_b : abs_a;
                            a_raw    <= opr_a;
                            neg_res  <= sign_a ^ sign_b;
                            neg_rem  <= sign_a;
                            zero_div <= in_div && (opr_b == '0);
                        end
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    dbz_q  <= zero_div;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed bench for muldiv_unit (WIDTH=32). Stimulus pushes hand-computed
// results into a scoreboard; a monitor pops and compares on every done pulse,
// including the cycle at which the result appears.
// Optional feature macro: MULDIV_MADD_EN selects the accumulate-op vectors.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] opr_a;
    logic [W-1:0] opr_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_rdata;
    logic [W-1:0] lo_rdata;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];
    logic         exp_dbz_q[$];
    int           exp_at_q[$];
    string        exp_name_q[$];

    muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .opr_a       (opr_a),
        .opr_b       (opr_b),
        .busy        (busy),
        .done        (done),
        .hi_rdata    (hi_rdata),
        .lo_rdata    (lo_rdata),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock and an edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge: drives one start pulse and, for multi-cycle ops,
    // queues the expected result and the edge it must appear after.
    task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit expect_res, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                                 input logic edbz, input string name);
        start = 1'b1;
        op    = o;
        opr_a = a;
        opr_b = b;
        if (expect_res) begin
            exp_hi_q.push_back(ehi);
            exp_lo_q.push_back(elo);
            exp_dbz_q.push_back(edbz);
            exp_at_q.push_back(cycle + 1 + W + 1);
            exp_name_q.push_back(name);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (exp_hi_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (exp_hi_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: got pending=%0d expected pending=0", exp_hi_q.size());
            exp_hi_q.delete();
            exp_lo_q.delete();
            exp_dbz_q.delete();
            exp_at_q.delete();
            exp_name_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_hi_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 expected done=0");
            end else begin
                automatic logic [W-1:0] eh = exp_hi_q.pop_front();
                automatic logic [W-1:0] el = exp_lo_q.pop_front();
                automatic logic         ed = exp_dbz_q.pop_front();
                automatic int           ea = exp_at_q.pop_front();
                automatic string        nm = exp_name_q.pop_front();
                checkOutput({nm, " hi"}, hi_rdata, eh);
                checkOutput({nm, " lo"}, lo_rdata, el);
                checkOutput({nm, " dbz"}, W'(div_by_zero), W'(ed));
                checkOutput({nm, " busy"}, W'(busy), 32'd0);
                checkOutput({nm, " cycle"}, W'(cycle), W'(ea));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        opr_a = '0;
        opr_b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset hi", hi_rdata, 32'h0);
        checkOutput("reset lo", lo_rdata, 32'h0);
        checkOutput("reset busy", W'(busy), 32'd0);
        checkOutput("reset done", W'(done), 32'd0);
        checkOutput("reset dbz", W'(div_by_zero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(OP_MTHI, 32'h12345678, 32'h0, 1'b0, '0, '0, 1'b0, "mthi");
        checkOutput("mthi hi", hi_rdata, 32'h12345678);
        checkOutput("mthi busy", W'(busy), 32'd0);
        applyStimulus(OP_MTLO, 32'h9ABCDEF0, 32'h0, 1'b0, '0, '0, 1'b0, "mtlo");
        checkOutput("mtlo lo", lo_rdata, 32'h9ABCDEF0);
        checkOutput("mtlo hi kept", hi_rdata, 32'h12345678);
        checkOutput("mtlo busy", W'(busy), 32'd0);

        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, "mult");
        checkOutput("mult busy", W'(busy), 32'd1);
        checkOutput("mult hi held", hi_rdata, 32'h12345678);
        waitDone();
        applyStimulus(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1, 32'h00000002, 32'hFFFFFFFA, 1'b0, "multu");
        waitDone();
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
        waitDone();
        applyStimulus(OP_MULT, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 1'b0, "mult_min");
        waitDone();
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg");
        waitDone();
        applyStimulus(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_negb");
        waitDone();
        applyStimulus(OP_DIVU, 32'd7, 32'd2, 1'b1, 32'h00000001, 32'h00000003, 1'b0, "divu");
        waitDone();

        applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b1, 32'h00000005, 32'hFFFFFFFF, 1'b1, "divu_zero");
        waitDone();
        repeat (3) @(negedge clk);
        checkOutput("dbz sticky", W'(div_by_zero), 32'd1);
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0, "div_ovf");
        checkOutput("dbz cleared", W'(div_by_zero), 32'd0);
        waitDone();
        applyStimulus(OP_DIV, 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, "div_zero");
        waitDone();

        // A second start while busy must neither restart nor disturb the op.
        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, "mult_busy");
        repeat (3) @(negedge clk);
        applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0, "ignored");
        checkOutput("ignored busy", W'(busy), 32'd1);
        waitDone();

        // Unrecognised encoding in IDLE does nothing.
        applyStimulus(4'd6, 32'hDEADBEEF, 32'd1, 1'b0, '0, '0, 1'b0, "op6");
        checkOutput("op6 busy", W'(busy), 32'd0);
        checkOutput("op6 hi", hi_rdata, 32'hFFFFFFFF);

`ifdef MULDIV_MADD_EN
        applyStimulus(OP_MTHI, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0, "mthi0");
        applyStimulus(OP_MTLO, 32'hFFFFFFFF, 32'h0, 1'b0, '0, '0, 1'b0, "mtlo1s");
        applyStimulus(OP_MADDU, 32'd1, 32'd1, 1'b1, 32'h00000001, 32'h00000000, 1'b0, "maddu");
        waitDone();
        applyStimulus(OP_MTHI, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0, "mthi0b");
        applyStimulus(OP_MTLO, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0, "mtlo0b");
        applyStimulus(OP_MSUB, 32'd2, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, "msub");
        waitDone();
`else
        applyStimulus(OP_MTHI, 32'h11, 32'h0, 1'b0, '0, '0, 1'b0, "mthi11");
        applyStimulus(OP_MTLO, 32'h22, 32'h0, 1'b0, '0, '0, 1'b0, "mtlo22");
        applyStimulus(OP_MADDU, 32'd1, 32'd1, 1'b0, '0, '0, 1'b0, "maddu_off");
        checkOutput("maddu_off busy", W'(busy), 32'd0);
        repeat (40) @(negedge clk);
        checkOutput("maddu_off hi", hi_rdata, 32'h11);
        checkOutput("maddu_off lo", lo_rdata, 32'h22);
`endif

        // Reset in the middle of a divide: HI/LO cleared, no done pulse.
        applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0, "div_abort");
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort hi", hi_rdata, 32'h0);
        checkOutput("abort lo", lo_rdata, 32'h0);
        checkOutput("abort busy", W'(busy), 32'd0);
        repeat (40) @(negedge clk);
        checkOutput("abort idle busy", W'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
